// File: rtl/bus_arbiter_n_pkg.sv
// Shared types, exception causes and helpers for the N-channel request/response arbiter.
package bus_arbiter_n_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [4:0] EXC_INSN_FAULT  = 5'd1;
    localparam logic [4:0] EXC_LOAD_FAULT  = 5'd5;
    localparam logic [4:0] EXC_STORE_FAULT = 5'd7;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    // Cause reported when the watchdog gives up on a transaction
    function automatic logic [4:0] fault_cause(input logic mode, input logic is_fetch);
        logic [4:0] cause;
        if (mode == MODE_WRITE) begin
            cause = EXC_STORE_FAULT;
        end else if (is_fetch) begin
            cause = EXC_INSN_FAULT;
        end else begin
            cause = EXC_LOAD_FAULT;
        end
        return cause;
    endfunction

endpackage

// File: rtl/bus_arbiter_n_if.sv
// Upstream channel bundle plus the single downstream memory/MMU port of the arbiter.
interface bus_arbiter_n_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [N_CH-1:0]        up_req_enable;
    logic [N_CH-1:0]        up_req_mode;
    logic [N_CH*ADDR_W-1:0] up_req_addr;
    logic [N_CH*DATA_W-1:0] up_req_wdata;
    logic [N_CH*STRB_W-1:0] up_req_wstrb;
    logic [N_CH-1:0]        up_resp_enable;
    logic [DATA_W-1:0]      up_resp_data;
    logic [N_CH-1:0]        up_exc_enable;
    logic [4:0]             up_exc_vec;
    logic [31:0]            up_exc_tval;
    logic                   dn_req_enable;
    logic                   dn_req_mode;
    logic [ADDR_W-1:0]      dn_req_addr;
    logic [DATA_W-1:0]      dn_req_wdata;
    logic [STRB_W-1:0]      dn_req_wstrb;
    logic                   dn_resp_enable;
    logic [DATA_W-1:0]      dn_resp_data;
    logic                   dn_exc_enable;
    logic [4:0]             dn_exc_vec;
    logic [31:0]            dn_exc_tval;
    logic [N_CH-1:0]        proto_err;

    modport slave (
        input  up_req_enable, up_req_mode, up_req_addr, up_req_wdata, up_req_wstrb,
        output up_resp_enable, up_resp_data, up_exc_enable, up_exc_vec, up_exc_tval,
        output dn_req_enable, dn_req_mode, dn_req_addr, dn_req_wdata, dn_req_wstrb,
        input  dn_resp_enable, dn_resp_data, dn_exc_enable, dn_exc_vec, dn_exc_tval,
        output proto_err
    );

    modport master (
        output up_req_enable, up_req_mode, up_req_addr, up_req_wdata, up_req_wstrb,
        input  up_resp_enable, up_resp_data, up_exc_enable, up_exc_vec, up_exc_tval,
        input  dn_req_enable, dn_req_mode, dn_req_addr, dn_req_wdata, dn_req_wstrb,
        output dn_resp_enable, dn_resp_data, dn_exc_enable, dn_exc_vec, dn_exc_tval,
        input  proto_err
    );

endinterface

// File: rtl/bus_arbiter_n_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping once.
module rr_pick
    import bus_arbiter_n_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int IDX_W = idx_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] probe_s;

    // Walk the channels in priority order starting from the pointer
    always_comb begin
        grant   = '0;
        idx     = '0;
        valid   = 1'b0;
        probe_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            probe_s = IDX_W'((int'(ptr) + k) % N_CH);
            if (!valid && req[probe_s]) begin
                valid          = 1'b1;
                idx            = probe_s;
                grant[probe_s] = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-channel request/response arbiter: per-channel pending slots, round-robin issue, one transaction
// outstanding, response/exception routing to the owner and an optional watchdog fault.
module bus_arbiter_n
    import bus_arbiter_n_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_n_if.slave bus
);

    localparam int               STRB_W  = DATA_W / 8;
    localparam int               IDX_W   = idx_width(N_CH);
    localparam int               WD_W    = idx_width(TIMEOUT + 32'sd1);
    localparam bit               WD_ON   = (TIMEOUT > 32'sd0);
    localparam logic [WD_W-1:0]  WD_END  = WD_W'(WD_ON ? TIMEOUT - 32'sd1 : 32'sd0);
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_CH - 32'sd1);

    state_e            state_r, state_next_s;
    logic [N_CH-1:0]   slot_valid_r, slot_mode_r, proto_err_r;
    logic [ADDR_W-1:0] slot_addr_r  [N_CH];
    logic [DATA_W-1:0] slot_wdata_r [N_CH];
    logic [STRB_W-1:0] slot_wstrb_r [N_CH];

    logic [N_CH-1:0]   cand_s, grant_oh_s, owner_oh_s;
    logic [IDX_W-1:0]  grant_idx_s, rr_ptr_r, owner_r;
    logic              grant_valid_s;
    logic              sel_mode_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [STRB_W-1:0] sel_wstrb_s;
    logic              issue_s, resp_done_s, exc_done_s, wd_done_s, wd_expire_s;
    logic [WD_W-1:0]   wd_r;

    logic              dn_req_enable_r, dn_req_mode_r;
    logic [ADDR_W-1:0] dn_req_addr_r;
    logic [DATA_W-1:0] dn_req_wdata_r;
    logic [STRB_W-1:0] dn_req_wstrb_r;
    logic [N_CH-1:0]   up_resp_enable_r, up_exc_enable_r;
    logic [DATA_W-1:0] up_resp_data_r;
    logic [4:0]        up_exc_vec_r;
    logic [31:0]       up_exc_tval_r;

    // A same-cycle pulse competes alongside stored requests
    assign cand_s      = slot_valid_r | bus.up_req_enable;
    assign wd_expire_s = WD_ON && (wd_r == WD_END);

    rr_pick #(.N_CH(N_CH), .IDX_W(IDX_W)) u_pick (
        .req   (cand_s),
        .ptr   (rr_ptr_r),
        .grant (grant_oh_s),
        .idx   (grant_idx_s),
        .valid (grant_valid_s)
    );

    // Winner's fields: a stored request is older than any pulse on the same channel
    always_comb begin
        if (slot_valid_r[grant_idx_s]) begin
            sel_mode_s  = slot_mode_r[grant_idx_s];
            sel_addr_s  = slot_addr_r[grant_idx_s];
            sel_wdata_s = slot_wdata_r[grant_idx_s];
            sel_wstrb_s = slot_wstrb_r[grant_idx_s];
        end else begin
            sel_mode_s  = bus.up_req_mode[grant_idx_s];
            sel_addr_s  = bus.up_req_addr[grant_idx_s*ADDR_W +: ADDR_W];
            sel_wdata_s = bus.up_req_wdata[grant_idx_s*DATA_W +: DATA_W];
            sel_wstrb_s = bus.up_req_wstrb[grant_idx_s*STRB_W +: STRB_W];
        end
    end

    // Owner index as a one-hot routing mask
    always_comb begin
        owner_oh_s          = '0;
        owner_oh_s[owner_r] = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) state_next_s = ST_WAIT;
                else               state_next_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (exc_done_s || resp_done_s || wd_done_s) state_next_s = ST_IDLE;
                else                                        state_next_s = ST_WAIT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs; exception beats response, and either beats the watchdog
    always_comb begin
        issue_s     = 1'b0;
        resp_done_s = 1'b0;
        exc_done_s  = 1'b0;
        wd_done_s   = 1'b0;
        case (state_r)
            ST_IDLE: issue_s = grant_valid_s;
            ST_WAIT: begin
                if (bus.dn_exc_enable)       exc_done_s  = 1'b1;
                else if (bus.dn_resp_enable) resp_done_s = 1'b1;
                else if (wd_expire_s)        wd_done_s   = 1'b1;
                else                         wd_done_s   = 1'b0;
            end
            default: issue_s = 1'b0;
        endcase
    end

    // Pending slots: a granted channel is cleared (stored entry issued or pulse bypassed)
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_r <= '0;
            slot_mode_r  <= '0;
            proto_err_r  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                slot_addr_r[i]  <= '0;
                slot_wdata_r[i] <= '0;
                slot_wstrb_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (issue_s && grant_oh_s[i]) begin
                    slot_valid_r[i] <= 1'b0;
                end else if (bus.up_req_enable[i] && !slot_valid_r[i]) begin
                    slot_valid_r[i] <= 1'b1;
                    slot_mode_r[i]  <= bus.up_req_mode[i];
                    slot_addr_r[i]  <= bus.up_req_addr[i*ADDR_W +: ADDR_W];
                    slot_wdata_r[i] <= bus.up_req_wdata[i*DATA_W +: DATA_W];
                    slot_wstrb_r[i] <= bus.up_req_wstrb[i*STRB_W +: STRB_W];
                end else begin
                    slot_valid_r[i] <= slot_valid_r[i];
                end
                if (bus.up_req_enable[i] && slot_valid_r[i]) begin
                    proto_err_r[i] <= 1'b1;
                end else begin
                    proto_err_r[i] <= proto_err_r[i];
                end
            end
        end
    end

    // Downstream issue, watchdog and upstream completion registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_req_enable_r  <= 1'b0;
            dn_req_mode_r    <= MODE_READ;
            dn_req_addr_r    <= '0;
            dn_req_wdata_r   <= '0;
            dn_req_wstrb_r   <= '0;
            owner_r          <= '0;
            rr_ptr_r         <= '0;
            wd_r             <= '0;
            up_resp_enable_r <= '0;
            up_resp_data_r   <= '0;
            up_exc_enable_r  <= '0;
            up_exc_vec_r     <= 5'd0;
            up_exc_tval_r    <= 32'd0;
        end else begin
            dn_req_enable_r  <= issue_s;
            up_resp_enable_r <= '0;
            up_exc_enable_r  <= '0;
            if (issue_s) begin
                dn_req_mode_r  <= sel_mode_s;
                dn_req_addr_r  <= sel_addr_s;
                dn_req_wdata_r <= sel_wdata_s;
                dn_req_wstrb_r <= sel_wstrb_s;
                owner_r        <= grant_idx_s;
                rr_ptr_r       <= (grant_idx_s == LAST_CH) ? '0 : grant_idx_s + 1'b1;
                wd_r           <= '0;
            end else if (state_r == ST_WAIT) begin
                wd_r <= wd_r + 1'b1;
            end else begin
                wd_r <= wd_r;
            end
            if (resp_done_s) begin
                up_resp_enable_r <= owner_oh_s;
                up_resp_data_r   <= bus.dn_resp_data;
            end else begin
                up_resp_data_r <= up_resp_data_r;
            end
            if (exc_done_s) begin
                up_exc_enable_r <= owner_oh_s;
                up_exc_vec_r    <= bus.dn_exc_vec;
                up_exc_tval_r   <= bus.dn_exc_tval;
            end else if (wd_done_s) begin
                up_exc_enable_r <= owner_oh_s;
                up_exc_vec_r    <= fault_cause(dn_req_mode_r, owner_r == '0);
                up_exc_tval_r   <= 32'(dn_req_addr_r);
            end else begin
                up_exc_vec_r <= up_exc_vec_r;
            end
        end
    end

    assign bus.dn_req_enable  = dn_req_enable_r;
    assign bus.dn_req_mode    = dn_req_mode_r;
    assign bus.dn_req_addr    = dn_req_addr_r;
    assign bus.dn_req_wdata   = dn_req_wdata_r;
    assign bus.dn_req_wstrb   = dn_req_wstrb_r;
    assign bus.up_resp_enable = up_resp_enable_r;
    assign bus.up_resp_data   = up_resp_data_r;
    assign bus.up_exc_enable  = up_exc_enable_r;
    assign bus.up_exc_vec     = up_exc_vec_r;
    assign bus.up_exc_tval    = up_exc_tval_r;
    assign bus.proto_err      = proto_err_r;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Scoreboard-driven bench for bus_arbiter_n (2 channels, 8-cycle watchdog).
module tb_bus_arbiter_n;
    import bus_arbiter_n_pkg::*;

    localparam int N_CH = 2, ADDR_W = 32, DATA_W = 32, TIMEOUT = 8;

    typedef struct { logic mode; logic [31:0] addr; } dn_exp_t;
    typedef struct { logic [1:0] mask; logic [31:0] data; logic [4:0] vec; logic [31:0] tval; } up_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    dn_exp_t dn_q[$];
    up_exp_t up_q[$];

    logic [1:0] round_en    [4] = '{2'b11, 2'b11, 2'b01, 2'b11};
    int         round_first [4] = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    bus_arbiter_n_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_arbiter_n #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.up_req_enable  = '0;
        bus.up_req_mode    = '0;
        bus.up_req_addr    = '0;
        bus.up_req_wdata   = '0;
        bus.up_req_wstrb   = '0;
        bus.dn_resp_enable = 1'b0;
        bus.dn_resp_data   = 32'd0;
        bus.dn_exc_enable  = 1'b0;
        bus.dn_exc_vec     = 5'd0;
        bus.dn_exc_tval    = 32'd0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        dn_q.delete();
        up_q.delete();
    endtask

    function automatic void push_dn(input logic mode, input logic [31:0] addr);
        dn_exp_t d;
        d.mode = mode;
        d.addr = addr;
        dn_q.push_back(d);
    endfunction

    function automatic void push_up(input logic [1:0] mask, input logic [31:0] data,
                                    input logic [4:0] vec, input logic [31:0] tval);
        up_exp_t u;
        u.mask = mask;
        u.data = data;
        u.vec  = vec;
        u.tval = tval;
        up_q.push_back(u);
    endfunction

    task automatic set_chan(input int ch, input logic mode, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb);
        bus.up_req_mode[ch]           = mode;
        bus.up_req_addr[ch*32 +: 32]  = addr;
        bus.up_req_wdata[ch*32 +: 32] = wdata;
        bus.up_req_wstrb[ch*4 +: 4]   = strb;
    endtask

    // One-cycle pulse on a channel; returns one cycle later
    task automatic send(input int ch, input logic mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
        set_chan(ch, mode, addr, wdata, strb);
        bus.up_req_enable[ch] = 1'b1;
        tick();
        bus.up_req_enable = '0;
    endtask

    task automatic respond(input logic [31:0] data);
        bus.dn_resp_enable = 1'b1;
        bus.dn_resp_data   = data;
        tick();
        bus.dn_resp_enable = 1'b0;
    endtask

    task automatic wait_dn(input int budget, output int n);
        n = 0;
        while (bus.dn_req_enable !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.dn_req_enable !== 1'b0 || bus.up_resp_enable !== 2'b00 || bus.up_exc_enable !== 2'b00) begin
            bad++;
            $display("FAIL reset_pulses: dn=%b resp=%b exc=%b, want 0/00/00", bus.dn_req_enable, bus.up_resp_enable, bus.up_exc_enable);
        end
        total++;
        if (bus.proto_err !== 2'b00 || bus.dn_req_addr !== 32'd0 || bus.dn_req_mode !== 1'b0 ||
            bus.up_exc_vec !== 5'd0 || bus.up_exc_tval !== 32'd0 || bus.up_resp_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_fields: perr=%b addr=%h vec=%0d tval=%h data=%h, want all zero", bus.proto_err, bus.dn_req_addr, bus.up_exc_vec, bus.up_exc_tval, bus.up_resp_data);
        end
    endtask

    task automatic test_single_read();
        dn_exp_t d;
        up_exp_t u;
        push_dn(MODE_READ, 32'h8000_0010);
        push_up(2'b10, 32'hDEAD_BEEF, 5'd0, 32'd0);
        send(1, MODE_READ, 32'h8000_0010, 32'd0, 4'h0);
        d = dn_q.pop_front();
        total++;
        if (bus.dn_req_enable !== 1'b1 || bus.dn_req_addr !== d.addr || bus.dn_req_mode !== d.mode) begin
            bad++;
            $display("FAIL read_issue: en=%b addr=%h mode=%b, want 1 %h %b", bus.dn_req_enable, bus.dn_req_addr, bus.dn_req_mode, d.addr, d.mode);
        end
        tick();
        total++;
        if (bus.dn_req_enable !== 1'b0 || bus.dn_req_addr !== d.addr) begin
            bad++;
            $display("FAIL read_issue_hold: en=%b addr=%h, want 0 %h", bus.dn_req_enable, bus.dn_req_addr, d.addr);
        end
        repeat (3) tick();
        respond(32'hDEAD_BEEF);
        u = up_q.pop_front();
        total++;
        if (bus.up_resp_enable !== u.mask || bus.up_resp_data !== u.data || bus.up_exc_enable !== 2'b00) begin
            bad++;
            $display("FAIL read_resp: en=%b data=%h exc=%b, want %b %h 00", bus.up_resp_enable, bus.up_resp_data, bus.up_exc_enable, u.mask, u.data);
        end
        tick();
        total++;
        if (bus.up_resp_enable !== 2'b00) begin
            bad++;
            $display("FAIL read_resp_pulse: en=%b, want 00", bus.up_resp_enable);
        end
    endtask

    task automatic test_rotation();
        dn_exp_t d;
        up_exp_t u;
        int n, ch, cnt;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            cnt = 0;
            for (int k = 0; k < 2; k++) begin
                ch = (round_first[r] + k) % 2;
                if (round_en[r][ch]) begin
                    push_dn(MODE_READ, 32'h100 + 32'(r * 16 + ch * 4));
                    push_up(2'(1 << ch), 32'hC0DE_0000 + 32'(r * 16 + ch), 5'd0, 32'd0);
                    cnt++;
                end
            end
            for (int c = 0; c < 2; c++) begin
                set_chan(c, MODE_READ, 32'h100 + 32'(r * 16 + c * 4), 32'd0, 4'h0);
            end
            bus.up_req_enable = round_en[r];
            tick();
            bus.up_req_enable = '0;
            for (int g = 0; g < cnt; g++) begin
                wait_dn(20, n);
                d = dn_q.pop_front();
                u = up_q.pop_front();
                total++;
                if (bus.dn_req_enable !== 1'b1 || n != g || bus.dn_req_addr !== d.addr) begin
                    bad++;
                    $display("FAIL rr_issue r%0d g%0d: en=%b wait=%0d addr=%h, want 1 %0d %h", r, g, bus.dn_req_enable, n, bus.dn_req_addr, g, d.addr);
                end
                respond(u.data);
                total++;
                if (bus.up_resp_enable !== u.mask || bus.up_resp_data !== u.data) begin
                    bad++;
                    $display("FAIL rr_resp r%0d g%0d: en=%b data=%h, want %b %h", r, g, bus.up_resp_enable, bus.up_resp_data, u.mask, u.data);
                end
            end
        end
    endtask

    task automatic test_mmu_exc();
        up_exp_t u;
        push_up(2'b10, 32'd0, 5'd15, 32'h0000_1000);
        send(1, MODE_WRITE, 32'h0000_1000, 32'hA5A5_5A5A, 4'b1010);
        total++;
        if (bus.dn_req_enable !== 1'b1 || bus.dn_req_mode !== 1'b1 || bus.dn_req_addr !== 32'h1000 ||
            bus.dn_req_wdata !== 32'hA5A5_5A5A || bus.dn_req_wstrb !== 4'b1010) begin
            bad++;
            $display("FAIL write_issue: en=%b mode=%b addr=%h wdata=%h strb=%b, want 1 1 1000 a5a55a5a 1010", bus.dn_req_enable, bus.dn_req_mode, bus.dn_req_addr, bus.dn_req_wdata, bus.dn_req_wstrb);
        end
        tick();
        bus.dn_exc_enable  = 1'b1;
        bus.dn_exc_vec     = 5'd15;
        bus.dn_exc_tval    = 32'h0000_1000;
        bus.dn_resp_enable = 1'b1;
        bus.dn_resp_data   = 32'h1234_5678;
        tick();
        drive_idle();
        u = up_q.pop_front();
        total++;
        if (bus.up_exc_enable !== u.mask || bus.up_exc_vec !== u.vec || bus.up_exc_tval !== u.tval) begin
            bad++;
            $display("FAIL mmu_exc: en=%b vec=%0d tval=%h, want %b %0d %h", bus.up_exc_enable, bus.up_exc_vec, bus.up_exc_tval, u.mask, u.vec, u.tval);
        end
        total++;
        if (bus.up_resp_enable !== 2'b00) begin
            bad++;
            $display("FAIL mmu_exc_no_resp: resp=%b, want 00", bus.up_resp_enable);
        end
        respond(32'h5555_AAAA);
        total++;
        if (bus.up_resp_enable !== 2'b00 || bus.up_exc_enable !== 2'b00 || bus.dn_req_enable !== 1'b0) begin
            bad++;
            $display("FAIL idle_resp_ignored: resp=%b exc=%b dn=%b, want 00 00 0", bus.up_resp_enable, bus.up_exc_enable, bus.dn_req_enable);
        end
    endtask

    task automatic test_watchdog();
        up_exp_t u;
        logic [4:0] want_vec [3] = '{5'd7, 5'd1, 5'd5};
        int         wd_ch    [3] = '{1, 0, 1};
        logic       wd_mode  [3] = '{MODE_WRITE, MODE_READ, MODE_READ};
        logic       early;
        for (int c = 0; c < 3; c++) begin
            push_up(2'(1 << wd_ch[c]), 32'd0, want_vec[c], 32'h2000 + 32'(c * 256));
            send(wd_ch[c], wd_mode[c], 32'h2000 + 32'(c * 256), 32'd0, 4'hF);
            total++;
            if (bus.dn_req_enable !== 1'b1) begin
                bad++;
                $display("FAIL wd_issue c%0d: en=%b, want 1", c, bus.dn_req_enable);
            end
            early = 1'b0;
            for (int k = 1; k < 8; k++) begin
                tick();
                if (bus.up_exc_enable !== 2'b00) early = 1'b1;
            end
            tick();
            u = up_q.pop_front();
            total++;
            if (early || bus.up_exc_enable !== u.mask || bus.up_exc_vec !== u.vec || bus.up_exc_tval !== u.tval) begin
                bad++;
                $display("FAIL wd_fault c%0d: early=%b en=%b vec=%0d tval=%h, want 0 %b %0d %h", c, early, bus.up_exc_enable, bus.up_exc_vec, bus.up_exc_tval, u.mask, u.vec, u.tval);
            end
        end
        repeat (2) tick();
        respond(32'hFEED_F00D);
        total++;
        if (bus.up_resp_enable !== 2'b00 || bus.up_exc_enable !== 2'b00) begin
            bad++;
            $display("FAIL wd_late_resp: resp=%b exc=%b, want 00 00", bus.up_resp_enable, bus.up_exc_enable);
        end
        send(1, MODE_READ, 32'h3000, 32'd0, 4'h0);
        repeat (7) tick();
        respond(32'h0000_7777);
        total++;
        if (bus.up_resp_enable !== 2'b10 || bus.up_resp_data !== 32'h7777 || bus.up_exc_enable !== 2'b00) begin
            bad++;
            $display("FAIL wd_last_cycle_resp: resp=%b data=%h exc=%b, want 10 00007777 00", bus.up_resp_enable, bus.up_resp_data, bus.up_exc_enable);
        end
    endtask

    task automatic test_proto_err();
        dn_exp_t d;
        logic spurious;
        do_reset();
        push_dn(MODE_READ, 32'h300);
        push_dn(MODE_READ, 32'h400);
        send(1, MODE_READ, 32'h300, 32'd0, 4'h0);
        d = dn_q.pop_front();
        total++;
        if (bus.dn_req_enable !== 1'b1 || bus.dn_req_addr !== d.addr) begin
            bad++;
            $display("FAIL perr_first_issue: en=%b addr=%h, want 1 %h", bus.dn_req_enable, bus.dn_req_addr, d.addr);
        end
        send(0, MODE_READ, 32'h400, 32'd0, 4'h0);
        send(0, MODE_READ, 32'h500, 32'd0, 4'h0);
        total++;
        if (bus.proto_err !== 2'b01) begin
            bad++;
            $display("FAIL perr_flag: proto_err=%b, want 01", bus.proto_err);
        end
        respond(32'h33);
        total++;
        if (bus.up_resp_enable !== 2'b10 || bus.dn_req_enable !== 1'b0) begin
            bad++;
            $display("FAIL perr_owner_resp: resp=%b dn=%b, want 10 0", bus.up_resp_enable, bus.dn_req_enable);
        end
        tick();
        d = dn_q.pop_front();
        total++;
        if (bus.dn_req_enable !== 1'b1 || bus.dn_req_addr !== d.addr) begin
            bad++;
            $display("FAIL perr_queued_issue: en=%b addr=%h, want 1 %h", bus.dn_req_enable, bus.dn_req_addr, d.addr);
        end
        respond(32'h44);
        spurious = 1'b0;
        repeat (6) begin
            tick();
            if (bus.dn_req_enable !== 1'b0) spurious = 1'b1;
        end
        total++;
        if (spurious || bus.proto_err !== 2'b01) begin
            bad++;
            $display("FAIL perr_dropped: extra_issue=%b proto_err=%b, want 0 01", spurious, bus.proto_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic spurious;
        send(0, MODE_READ, 32'h600, 32'd0, 4'h0);
        send(1, MODE_READ, 32'h700, 32'd0, 4'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        respond(32'h0BAD_0BAD);
        total++;
        if (bus.up_resp_enable !== 2'b00 || bus.up_exc_enable !== 2'b00 || bus.dn_req_enable !== 1'b0 ||
            bus.proto_err !== 2'b00 || bus.dn_req_addr !== 32'd0 || bus.up_resp_data !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_wait: resp=%b exc=%b dn=%b perr=%b addr=%h data=%h, want all zero", bus.up_resp_enable, bus.up_exc_enable, bus.dn_req_enable, bus.proto_err, bus.dn_req_addr, bus.up_resp_data);
        end
        spurious = 1'b0;
        repeat (4) begin
            tick();
            if (bus.dn_req_enable !== 1'b0) spurious = 1'b1;
        end
        total++;
        if (spurious) begin
            bad++;
            $display("FAIL rst_slots_discarded: extra_issue=%b, want 0", spurious);
        end
        send(1, MODE_READ, 32'h800, 32'd0, 4'h0);
        total++;
        if (bus.dn_req_enable !== 1'b1 || bus.dn_req_addr !== 32'h800) begin
            bad++;
            $display("FAIL rst_idle_issue: en=%b addr=%h, want 1 00000800", bus.dn_req_enable, bus.dn_req_addr);
        end
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_rotation();
        test_mmu_exc();
        test_watchdog();
        test_proto_err();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "bench time limit");
    end

endmodule
